// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Extracts load data, selects the GPR write value,
// owns the architectural HI/LO registers and the retired-instruction counter,
// and commits each instruction exactly once even when MEM/WB holds it.
module wb_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rset,
  input  logic                valid_in,
  input  logic                hold_in,
  input  logic [31:0]         PC_in,
  input  logic [4:0]          registerW_in,
  input  logic                rf_we_in,
  input  logic                mem_to_reg_in,
  input  logic                cp0_to_reg_in,
  input  logic                mfhi_in,
  input  logic                mflo_in,
  input  logic                hilo_we_in,
  input  logic                mthi_in,
  input  logic                mtlo_in,
  input  logic [2:0]          sel_in,
  input  logic [1:0]          addr_byte_in,
  input  logic [31:0]         value_ALU_in,
  input  logic [31:0]         value_Data_in,
  input  logic [63:0]         HILO_in,
  input  logic [31:0]         rdata1_in,
  input  logic [31:0]         cp0_data_in,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata,
  output logic [RETIRE_W-1:0] retire_count
);

  // READY: the presented instruction has not been committed yet.
  // DONE: the presented instruction was already committed and is being held.
  typedef enum logic {
    READY = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        commit;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] result;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  localparam logic [RETIRE_W-1:0] COUNT_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  // State register; reset lands in READY so a still-presented instruction recommits.
  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  // Commit once per instruction; a held valid instruction moves to DONE, anything else to READY.
  always_comb begin
    state_next = READY;
    commit     = 1'b0;
    if (!rset && valid_in && (state == READY)) begin
      commit = 1'b1;
    end
    if (valid_in && hold_in) begin
      state_next = DONE;
    end
  end

  // Little-endian lane selection: byte by addr_byte_in, halfword by addr_byte_in[1].
  always_comb begin
    load_byte = value_Data_in[7:0];
    case (addr_byte_in)
      2'd0: load_byte = value_Data_in[7:0];
      2'd1: load_byte = value_Data_in[15:8];
      2'd2: load_byte = value_Data_in[23:16];
      2'd3: load_byte = value_Data_in[31:24];
      default: load_byte = value_Data_in[7:0];
    endcase
    load_half = addr_byte_in[1] ? value_Data_in[31:16] : value_Data_in[15:0];
  end

  // Extend the selected lane according to the load type; unused encodings act as LW.
  always_comb begin
    load_value = value_Data_in;
    case (sel_in)
      3'd1:    load_value = {{24{load_byte[7]}}, load_byte};
      3'd2:    load_value = {24'h000000, load_byte};
      3'd3:    load_value = {{16{load_half[15]}}, load_half};
      3'd4:    load_value = {16'h0000, load_half};
      default: load_value = value_Data_in;
    endcase
  end

  // Result priority: CP0 read, then HI, then LO, then load data, then ALU.
  always_comb begin
    result = value_ALU_in;
    if (cp0_to_reg_in) begin
      result = cp0_data_in;
    end else if (mfhi_in) begin
      result = hi_reg;
    end else if (mflo_in) begin
      result = lo_reg;
    end else if (mem_to_reg_in) begin
      result = load_value;
    end
  end

  // HI/LO update only on a commit edge; a full HILO write overrides MTHI/MTLO.
  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      hi_reg <= 32'h0;
      lo_reg <= 32'h0;
    end else if (commit) begin
      if (hilo_we_in) begin
        hi_reg <= HILO_in[63:32];
        lo_reg <= HILO_in[31:0];
      end else begin
        if (mthi_in) begin
          hi_reg <= rdata1_in;
        end
        if (mtlo_in) begin
          lo_reg <= rdata1_in;
        end
      end
    end
  end

  // Count every committed instruction, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      retire_count <= '0;
    end else if (commit) begin
      retire_count <= retire_count + COUNT_ONE;
    end
  end

  assign rf_we             = commit & rf_we_in & (registerW_in != 5'd0);
  assign rf_waddr          = registerW_in;
  assign rf_wdata          = result;
  assign hi_out            = hi_reg;
  assign lo_out            = lo_reg;
  assign debug_wb_pc       = PC_in;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = registerW_in;
  assign debug_wb_rf_wdata = result;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. The stimulus process computes the
// expected per-cycle outputs from an instruction-level model and queues them;
// a monitor process compares them against the DUT on the falling edge.
module tb_wb_stage;

  typedef struct {
    logic        valid;
    logic        hold;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        m2r;
    logic        cp0;
    logic        mfhi;
    logic        mflo;
    logic        hilo_we;
    logic        mthi;
    logic        mtlo;
    logic [2:0]  sel;
    logic [1:0]  ab;
    logic [31:0] alu;
    logic [31:0] data;
    logic [63:0] hilo;
    logic [31:0] rs;
    logic [31:0] cp0d;
  } instr_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cnt;
  } expect_t;

  logic        clk;
  logic        rset;
  instr_t      drv;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retire_count;

  expect_t     sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Instruction-level model state.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_cnt;
  bit          m_already_committed;

  wb_stage #(.RETIRE_W(32)) dut (
    .clk               (clk),
    .rset              (rset),
    .valid_in          (drv.valid),
    .hold_in           (drv.hold),
    .PC_in             (drv.pc),
    .registerW_in      (drv.rd),
    .rf_we_in          (drv.we),
    .mem_to_reg_in     (drv.m2r),
    .cp0_to_reg_in     (drv.cp0),
    .mfhi_in           (drv.mfhi),
    .mflo_in           (drv.mflo),
    .hilo_we_in        (drv.hilo_we),
    .mthi_in           (drv.mthi),
    .mtlo_in           (drv.mtlo),
    .sel_in            (drv.sel),
    .addr_byte_in      (drv.ab),
    .value_ALU_in      (drv.alu),
    .value_Data_in     (drv.data),
    .HILO_in           (drv.hilo),
    .rdata1_in         (drv.rs),
    .cp0_data_in       (drv.cp0d),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .hi_out            (hi_out),
    .lo_out            (lo_out),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_count      (retire_count)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic instr_t blank_instr();
    instr_t i;
    i.valid = 1'b0; i.hold = 1'b0; i.pc = 32'h0; i.rd = 5'd0; i.we = 1'b0;
    i.m2r = 1'b0; i.cp0 = 1'b0; i.mfhi = 1'b0; i.mflo = 1'b0; i.hilo_we = 1'b0;
    i.mthi = 1'b0; i.mtlo = 1'b0; i.sel = 3'd0; i.ab = 2'd0; i.alu = 32'h0;
    i.data = 32'h0; i.hilo = 64'h0; i.rs = 32'h0; i.cp0d = 32'h0;
    return i;
  endfunction

  // Load extraction written as shifts and masks on the raw word.
  function automatic logic [31:0] model_load(input logic [2:0] sel, input logic [1:0] ab, input logic [31:0] data);
    logic [31:0] b;
    logic [31:0] h;
    int          half_idx;
    b = (data >> (8 * int'(ab))) & 32'h0000_00FF;
    half_idx = (ab >= 2'd2) ? 1 : 0;
    h = (data >> (16 * half_idx)) & 32'h0000_FFFF;
    case (sel)
      3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input instr_t i);
    if (i.cp0)  return i.cp0d;
    if (i.mfhi) return m_hi;
    if (i.mflo) return m_lo;
    if (i.m2r)  return model_load(i.sel, i.ab, i.data);
    return i.alu;
  endfunction

  // Present one instruction for one cycle, queue the expected outputs, then advance the model.
  task automatic apply_stimulus(input instr_t i);
    expect_t e;
    bit      commits;
    drv = i;
    commits = i.valid && !m_already_committed;
    e.we    = commits && i.we && (i.rd != 5'd0);
    e.waddr = i.rd;
    e.wdata = model_result(i);
    e.pc    = i.pc;
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    if (commits) begin
      m_cnt = m_cnt + 32'd1;
      if (i.hilo_we) begin
        m_hi = i.hilo[63:32];
        m_lo = i.hilo[31:0];
      end else begin
        if (i.mthi) m_hi = i.rs;
        if (i.mtlo) m_lo = i.rs;
      end
    end
    m_already_committed = i.valid && i.hold;
    #1;
  endtask

  // Assert reset asynchronously while an instruction that would commit is presented.
  task automatic apply_reset(input instr_t i);
    drv = i;
    rset = 1'b1;
    #1;
    check_output("reset_rf_we", {63'h0, rf_we}, 64'h0);
    check_output("reset_dbg_wen", {60'h0, debug_wb_rf_wen}, 64'h0);
    check_output("reset_hi", {32'h0, hi_out}, 64'h0);
    check_output("reset_lo", {32'h0, lo_out}, 64'h0);
    check_output("reset_count", {32'h0, retire_count}, 64'h0);
    @(posedge clk);
    #1;
    rset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    m_cnt = 32'h0;
    m_already_committed = 1'b0;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation on each falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output("rf_we", {63'h0, rf_we}, {63'h0, e.we});
        check_output("rf_waddr", {59'h0, rf_waddr}, {59'h0, e.waddr});
        check_output("rf_wdata", {32'h0, rf_wdata}, {32'h0, e.wdata});
        check_output("hi_out", {32'h0, hi_out}, {32'h0, e.hi});
        check_output("lo_out", {32'h0, lo_out}, {32'h0, e.lo});
        check_output("retire_count", {32'h0, retire_count}, {32'h0, e.cnt});
        check_output("dbg_pc", {32'h0, debug_wb_pc}, {32'h0, e.pc});
        check_output("dbg_wen", {60'h0, debug_wb_rf_wen}, {60'h0, {4{e.we}}});
        check_output("dbg_wnum", {59'h0, debug_wb_rf_wnum}, {59'h0, e.waddr});
        check_output("dbg_wdata", {32'h0, debug_wb_rf_wdata}, {32'h0, e.wdata});
      end
    end
  end

  // Directed scenarios followed by randomized instruction streams.
  initial begin
    instr_t i;
    instr_t prev;
    int     kind;
    drv = blank_instr();
    m_hi = 32'h0;
    m_lo = 32'h0;
    m_cnt = 32'h0;
    m_already_committed = 1'b0;

    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd9;
    rset = 1'b1;
    drv = i;
    #3;
    check_output("init_rf_we", {63'h0, rf_we}, 64'h0);
    check_output("init_count", {32'h0, retire_count}, 64'h0);
    check_output("init_hi", {32'h0, hi_out}, 64'h0);
    @(posedge clk);
    #1;
    rset = 1'b0;

    // Byte and halfword loads from the same word.
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd5; i.m2r = 1'b1; i.pc = 32'hBFC0_0100;
    i.data = 32'h12B4_5680; i.ab = 2'd2; i.alu = 32'h8000_0002;
    i.sel = 3'd1; apply_stimulus(i);
    i.sel = 3'd2; i.pc = 32'hBFC0_0104; apply_stimulus(i);
    i.sel = 3'd3; i.pc = 32'hBFC0_0108; apply_stimulus(i);
    i.sel = 3'd4; i.ab = 2'd0; i.pc = 32'hBFC0_010C; apply_stimulus(i);
    i.sel = 3'd1; i.ab = 2'd1; i.pc = 32'hBFC0_0110; apply_stimulus(i);

    // ADDU held for three extra cycles: one commit only.
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd3; i.alu = 32'h0000_0007; i.pc = 32'hBFC0_0200;
    i.hold = 1'b1;
    apply_stimulus(i); apply_stimulus(i); apply_stimulus(i);
    i.hold = 1'b0;
    apply_stimulus(i);

    // MULT, MFLO, MTHI, MFHI back to back.
    i = blank_instr();
    i.valid = 1'b1; i.hilo_we = 1'b1; i.hilo = 64'h0000_0001_FFFF_FFFE; i.mthi = 1'b1;
    i.rs = 32'h1111_1111; i.pc = 32'hBFC0_0300;
    apply_stimulus(i);
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd4; i.mflo = 1'b1; i.pc = 32'hBFC0_0304;
    apply_stimulus(i);
    i = blank_instr();
    i.valid = 1'b1; i.mthi = 1'b1; i.rs = 32'hA5A5_A5A5; i.pc = 32'hBFC0_0308;
    apply_stimulus(i);
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd6; i.mfhi = 1'b1; i.mflo = 1'b1; i.pc = 32'hBFC0_030C;
    apply_stimulus(i);

    // r0 destination still retires; bubble does nothing.
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd0; i.alu = 32'hDEAD_BEEF; i.pc = 32'hBFC0_0400;
    apply_stimulus(i);
    i.valid = 1'b0; i.rd = 5'd8; i.hold = 1'b1;
    apply_stimulus(i);

    // CP0 wins over load data.
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd12; i.cp0 = 1'b1; i.m2r = 1'b1; i.mfhi = 1'b1;
    i.cp0d = 32'hBFC0_0380; i.data = 32'h1234_5678; i.pc = 32'hBFC0_0500;
    apply_stimulus(i);

    // Reset mid-hold: the still-presented instruction commits again afterwards.
    i = blank_instr();
    i.valid = 1'b1; i.we = 1'b1; i.rd = 5'd7; i.alu = 32'h0000_0042; i.hold = 1'b1;
    i.pc = 32'hBFC0_0600;
    apply_stimulus(i);
    apply_reset(i);
    i.hold = 1'b0;
    apply_stimulus(i);

    // Randomized stream; held instructions are re-presented unchanged.
    prev = blank_instr();
    for (int n = 0; n < 400; n++) begin
      if (prev.valid && prev.hold && ($urandom_range(0, 9) != 0)) begin
        i = prev;
        i.hold = ($urandom_range(0, 2) != 0);
      end else begin
        i = blank_instr();
        i.valid = ($urandom_range(0, 99) < 85);
        i.hold  = ($urandom_range(0, 99) < 30);
        i.pc    = $urandom & 32'hFFFF_FFFC;
        i.rd    = 5'($urandom_range(0, 31));
        i.we    = ($urandom_range(0, 3) != 0);
        i.sel   = 3'($urandom_range(0, 7));
        i.ab    = 2'($urandom_range(0, 3));
        i.alu   = $urandom;
        i.data  = $urandom;
        i.hilo  = {$urandom, $urandom};
        i.rs    = $urandom;
        i.cp0d  = $urandom;
        kind = $urandom_range(0, 9);
        case (kind)
          0: i.hilo_we = 1'b1;
          1: i.mthi = 1'b1;
          2: i.mtlo = 1'b1;
          3: i.mfhi = 1'b1;
          4: i.mflo = 1'b1;
          5: i.cp0 = 1'b1;
          6, 7: i.m2r = 1'b1;
          default: ;
        endcase
        if ($urandom_range(0, 7) == 0) i.mthi = 1'b1;
        if ($urandom_range(0, 7) == 0) i.mtlo = 1'b1;
        if ($urandom_range(0, 7) == 0) i.m2r = 1'b1;
      end
      apply_stimulus(i);
      prev = i;
      if ($urandom_range(0, 199) == 0) begin
        apply_reset(i);
        prev = blank_instr();
      end
    end

    drv = blank_instr();
    @(negedge clk);
    @(negedge clk);
    check_output("scoreboard_drained", {32'h0, 32'(sb_q.size())}, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
